axi_lite_write_fifo: RTL and testbench

AXI-Lite slave that accepts single-beat writes to one word address and pushes each accepted data word into an internal FIFO. The FIFO drains through a valid/ready stream output. It is the write-side counterpart of the team's AXI-Lite read FIFO: a bus master feeds a hardware stream consumer through it.

---
 rtl/axi_lite_pkg.sv | 28 ++
 rtl/axi_lite_write_fifo_if.sv | 42 ++++
 rtl/sync_fifo.sv | 59 +++++
 rtl/axi_lite_write_fifo.sv | 163 ++++++++++++++++
 tb/tb_axi_lite_write_fifo.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions used by the write FIFO and the read FIFO.
package axi_lite_pkg;

    localparam logic [1:0] RSP_OKAY   = 2'b00;
    localparam logic [1:0] RSP_EXOKAY = 2'b01;
    localparam logic [1:0] RSP_SLVERR = 2'b10;
    localparam logic [1:0] RSP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_WAIT_W  = 2'd1,
        WR_WAIT_AW = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_e;

    function automatic logic [1:0] wr_resp_code(input logic pushed);
        return pushed ? RSP_OKAY : RSP_SLVERR;
    endfunction

    function automatic logic rsp_is_error(input logic [1:0] rsp);
        return (rsp == RSP_SLVERR) || (rsp == RSP_DECERR);
    endfunction

    function automatic logic rsp_is_ok(input logic [1:0] rsp);
        return (rsp == RSP_OKAY) || (rsp == RSP_EXOKAY);
    endfunction

endpackage

// File: rtl/axi_lite_write_fifo_if.sv
// AXI-Lite write-channel bundle (AW, W, B) shared by master and slave.
interface axi_lite_write_fifo_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BUS_WIDTH  = 32
);
    logic                     s_axi_awready;
    logic                     s_axi_awvalid;
    logic [ADDR_WIDTH-1:0]    s_axi_awaddr;
    logic                     s_axi_wready;
    logic                     s_axi_wvalid;
    logic [BUS_WIDTH-1:0]     s_axi_wdata;
    logic [BUS_WIDTH/8-1:0]   s_axi_wstrb;
    logic                     s_axi_bready;
    logic                     s_axi_bvalid;
    logic [1:0]               s_axi_bresp;

    modport slave (
        output s_axi_awready,
        input  s_axi_awvalid,
        input  s_axi_awaddr,
        output s_axi_wready,
        input  s_axi_wvalid,
        input  s_axi_wdata,
        input  s_axi_wstrb,
        input  s_axi_bready,
        output s_axi_bvalid,
        output s_axi_bresp
    );

    modport master (
        input  s_axi_awready,
        output s_axi_awvalid,
        output s_axi_awaddr,
        input  s_axi_wready,
        output s_axi_wvalid,
        output s_axi_wdata,
        output s_axi_wstrb,
        output s_axi_bready,
        input  s_axi_bvalid,
        input  s_axi_bresp
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a count register; all DEPTH entries are usable.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == DEPTH_C);
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign dout_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/axi_lite_write_fifo.sv
// AXI-Lite slave that pushes single-beat writes to one register into a
// FIFO drained through a valid/ready stream.
module axi_lite_write_fifo
    import axi_lite_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            BUS_WIDTH  = 32,
    parameter int unsigned            DEPTH      = 8,
    parameter logic [ADDR_WIDTH-1:0]  ADDRESS    = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_lite_write_fifo_if.slave  s_axi,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [BUS_WIDTH-1:0]  data_out
);
    localparam int unsigned ADDR_ALIGN = $clog2(BUS_WIDTH / 8);
    localparam logic [ADDR_WIDTH-ADDR_ALIGN-1:0] ADDR_HI = ADDRESS[ADDR_WIDTH-1:ADDR_ALIGN];

    wr_state_e              state_q;
    logic                   awready_q;
    logic                   bvalid_q;
    logic [1:0]             bresp_q;
    logic                   addr_ok_q;
    logic                   strb_ok_q;
    logic [BUS_WIDTH-1:0]   wdata_q;

    logic                   full_s;
    logic                   empty_s;
    logic                   wready_s;
    logic                   aw_hs_s;
    logic                   w_hs_s;
    logic                   addr_match_s;
    logic                   strb_all_s;
    logic                   push_s;
    logic                   pop_s;
    logic [BUS_WIDTH-1:0]   push_data_s;
    logic [1:0]             resp_d;

    assign addr_match_s = (s_axi.s_axi_awaddr[ADDR_WIDTH-1:ADDR_ALIGN] == ADDR_HI);
    assign strb_all_s   = &s_axi.s_axi_wstrb;
    // wready uses the registered count, so a pop only frees W on the next cycle.
    assign wready_s     = ((state_q == WR_IDLE) || (state_q == WR_WAIT_W)) && !full_s;
    assign aw_hs_s      = s_axi.s_axi_awvalid && awready_q;
    assign w_hs_s       = s_axi.s_axi_wvalid && wready_s;
    assign pop_s        = valid_out && ready_out;
    assign resp_d       = wr_resp_code(push_s);

    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = wready_s;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign valid_out           = !empty_s;

    // Push decision on the edge entering RESP, mixing captured and live fields.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = s_axi.s_axi_wdata;
        case (state_q)
            WR_IDLE: begin
                push_s = aw_hs_s && w_hs_s && addr_match_s && strb_all_s;
            end
            WR_WAIT_W: begin
                push_s = w_hs_s && addr_ok_q && strb_all_s;
            end
            WR_WAIT_AW: begin
                push_s      = aw_hs_s && addr_match_s && strb_ok_q;
                push_data_s = wdata_q;
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Write FSM with its capture registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WR_IDLE;
            awready_q <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RSP_OKAY;
            addr_ok_q <= 1'b0;
            strb_ok_q <= 1'b0;
            wdata_q   <= {BUS_WIDTH{1'b0}};
        end else begin
            if (aw_hs_s) begin
                addr_ok_q <= addr_match_s;
            end
            if (w_hs_s) begin
                wdata_q   <= s_axi.s_axi_wdata;
                strb_ok_q <= strb_all_s;
            end
            case (state_q)
                WR_IDLE: begin
                    if (aw_hs_s && w_hs_s) begin
                        state_q   <= WR_RESP;
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= resp_d;
                    end else if (aw_hs_s) begin
                        state_q   <= WR_WAIT_W;
                        awready_q <= 1'b0;
                    end else if (w_hs_s) begin
                        state_q   <= WR_WAIT_AW;
                    end else begin
                        state_q   <= WR_IDLE;
                    end
                end
                WR_WAIT_W: begin
                    if (w_hs_s) begin
                        state_q  <= WR_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= resp_d;
                    end else begin
                        state_q  <= WR_WAIT_W;
                    end
                end
                WR_WAIT_AW: begin
                    if (aw_hs_s) begin
                        state_q   <= WR_RESP;
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= resp_d;
                    end else begin
                        state_q   <= WR_WAIT_AW;
                    end
                end
                WR_RESP: begin
                    if (s_axi.s_axi_bready) begin
                        state_q   <= WR_IDLE;
                        awready_q <= 1'b1;
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RSP_OKAY;
                    end else begin
                        state_q   <= WR_RESP;
                    end
                end
                default: begin
                    state_q   <= WR_IDLE;
                    awready_q <= 1'b1;
                    bvalid_q  <= 1'b0;
                    bresp_q   <= RSP_OKAY;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .din_i   (push_data_s),
        .dout_o  (data_out)
    );
endmodule

// File: tb/tb_axi_lite_write_fifo.sv
// Directed bench: per-cycle vector table plus hand-written corner sequences.
module tb_axi_lite_write_fifo;
    localparam logic [31:0] A = 32'h0000_0040;

    logic        clk;
    logic        reset;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] data_out;
    int          n_cmp;
    int          n_fail;

    axi_lite_write_fifo_if #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) bus ();

    axi_lite_write_fifo #(
        .ADDR_WIDTH (32),
        .BUS_WIDTH  (32),
        .DEPTH      (8),
        .ADDRESS    (A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_axi     (bus),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        aw;
        logic [31:0] addr;
        logic        w;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        bready;
        logic        rdy;
        logic        e_awr;
        logic        e_wr;
        logic        e_bv;
        logic [1:0]  e_br;
        logic        e_vo;
        logic [31:0] e_do;
    } vec_t;

    vec_t vecs [22];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_awaddr  = 32'h0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_wdata   = 32'h0;
        bus.s_axi_wstrb   = 4'h0;
        bus.s_axi_bready  = 1'b0;
        ready_out         = 1'b0;
    endtask

    // Present AW and W together, dropping each valid once it has handshaken.
    task automatic axi_send(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic aw_f;
        logic w_f;
        int   n;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_wdata   = data;
        bus.s_axi_wstrb   = strb;
        n = 0;
        while ((bus.s_axi_awvalid || bus.s_axi_wvalid) && n < 20) begin
            aw_f = bus.s_axi_awvalid && bus.s_axi_awready;
            w_f  = bus.s_axi_wvalid && bus.s_axi_wready;
            tick();
            if (aw_f) bus.s_axi_awvalid = 1'b0;
            if (w_f)  bus.s_axi_wvalid  = 1'b0;
            n++;
        end
        chk("send_timeout", {62'd0, bus.s_axi_awvalid, bus.s_axi_wvalid}, 64'd0);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
    endtask

    task automatic axi_resp(input string name, input logic [1:0] exp);
        int n;
        n = 0;
        while (!bus.s_axi_bvalid && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_bvalid"}, {63'd0, bus.s_axi_bvalid}, 64'd1);
        chk({name, "_bresp"}, {62'd0, bus.s_axi_bresp}, {62'd0, exp});
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0;
        chk({name, "_bvalid_drop"}, {63'd0, bus.s_axi_bvalid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        //           aw addr       w  data          strb   br rdy  awr wr bv br     vo do
        vecs[0]  = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, A,         1'b1, 32'hDEADBEEF,  4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, A,         1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0,     1'b1, 32'h11111111,  4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h11111111};
        vecs[8]  = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h11111111};
        vecs[9]  = '{1'b0, 32'h0,     1'b1, 32'h22222222,  4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h11111111};
        vecs[10] = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h11111111};
        vecs[11] = '{1'b1, A,         1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h11111111};
        vecs[12] = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h11111111};
        vecs[13] = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h22222222};
        vecs[14] = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[15] = '{1'b1, A + 32'd4, 1'b1, 32'h33333333,  4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[18] = '{1'b1, A,         1'b1, 32'h44444444,  4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[20] = '{1'b1, A + 32'd3, 1'b1, 32'h55555555,  4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h55555555};
        vecs[21] = '{1'b0, 32'h0,     1'b0, 32'h0,         4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0};

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            bus.s_axi_awvalid = vecs[i].aw;
            bus.s_axi_awaddr  = vecs[i].addr;
            bus.s_axi_wvalid  = vecs[i].w;
            bus.s_axi_wdata   = vecs[i].data;
            bus.s_axi_wstrb   = vecs[i].strb;
            bus.s_axi_bready  = vecs[i].bready;
            ready_out         = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_awready", i), {63'd0, bus.s_axi_awready}, {63'd0, vecs[i].e_awr});
            chk($sformatf("v%0d_wready", i),  {63'd0, bus.s_axi_wready},  {63'd0, vecs[i].e_wr});
            chk($sformatf("v%0d_bvalid", i),  {63'd0, bus.s_axi_bvalid},  {63'd0, vecs[i].e_bv});
            chk($sformatf("v%0d_bresp", i),   {62'd0, bus.s_axi_bresp},   {62'd0, vecs[i].e_br});
            chk($sformatf("v%0d_valid_out", i), {63'd0, valid_out},       {63'd0, vecs[i].e_vo});
            chk($sformatf("v%0d_data_out", i),  {32'd0, data_out},        {32'd0, vecs[i].e_do});
        end
        idle_inputs();

        // Fill to full with the read side stalled, then stall the ninth W.
        for (int i = 0; i < 8; i++) begin
            axi_send(A, 32'(i), 4'hF);
            axi_resp("fill", 2'b00);
        end
        chk("full_wready", {63'd0, bus.s_axi_wready}, 64'd0);
        chk("full_awready", {63'd0, bus.s_axi_awready}, 64'd1);
        chk("full_data_out", {32'd0, data_out}, 64'd0);
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_awaddr  = A;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_wdata   = 32'd8;
        bus.s_axi_wstrb   = 4'hF;
        tick();
        bus.s_axi_awvalid = 1'b0;
        chk("w9_awready", {63'd0, bus.s_axi_awready}, 64'd0);
        chk("w9_wready_full", {63'd0, bus.s_axi_wready}, 64'd0);
        tick();
        chk("w9_still_stalled", {63'd0, bus.s_axi_wready}, 64'd0);
        ready_out = 1'b1;
        chk("pop_head", {32'd0, data_out}, 64'd0);
        chk("pop_cycle_wready", {63'd0, bus.s_axi_wready}, 64'd0);
        tick();
        ready_out = 1'b0;
        chk("after_pop_wready", {63'd0, bus.s_axi_wready}, 64'd1);
        chk("after_pop_bvalid", {63'd0, bus.s_axi_bvalid}, 64'd0);
        chk("after_pop_head", {32'd0, data_out}, 64'd1);
        tick();
        bus.s_axi_wvalid = 1'b0;
        axi_resp("w9", 2'b00);
        ready_out = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain_valid_%0d", i), {63'd0, valid_out}, 64'd1);
            chk($sformatf("drain_data_%0d", i), {32'd0, data_out}, 64'(i));
            tick();
        end
        ready_out = 1'b0;
        chk("drain_empty", {63'd0, valid_out}, 64'd0);

        // Push and pop on the same edge with four entries queued.
        for (int i = 0; i < 4; i++) begin
            axi_send(A, 32'hA0 + 32'(i), 4'hF);
            axi_resp("pp_fill", 2'b00);
        end
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_awaddr  = A;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_wdata   = 32'hA4;
        bus.s_axi_wstrb   = 4'hF;
        ready_out         = 1'b1;
        tick();
        idle_inputs();
        chk("pp_head", {32'd0, data_out}, 64'hA1);
        axi_resp("pp", 2'b00);
        ready_out = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("pp_data_%0d", i), {32'd0, data_out}, 64'hA0 + 64'(i));
            tick();
        end
        ready_out = 1'b0;
        chk("pp_empty", {63'd0, valid_out}, 64'd0);

        // Reset while a response is pending and three entries are queued.
        for (int i = 0; i < 2; i++) begin
            axi_send(A, 32'hB0 + 32'(i), 4'hF);
            axi_resp("rst_fill", 2'b00);
        end
        axi_send(A, 32'hB2, 4'hF);
        chk("rst_pre_bvalid", {63'd0, bus.s_axi_bvalid}, 64'd1);
        chk("rst_pre_valid", {63'd0, valid_out}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_bvalid", {63'd0, bus.s_axi_bvalid}, 64'd0);
        chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
        chk("rst_awready", {63'd0, bus.s_axi_awready}, 64'd1);
        chk("rst_wready", {63'd0, bus.s_axi_wready}, 64'd1);
        chk("rst_data_out", {32'd0, data_out}, 64'd0);
        axi_send(A, 32'hCAFEF00D, 4'hF);
        axi_resp("post_rst", 2'b00);
        chk("post_rst_valid", {63'd0, valid_out}, 64'd1);
        chk("post_rst_data", {32'd0, data_out}, 64'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
